// File: rtl/move_checker.sv
// move_checker: sequential collision check for the active tetromino.
// Given a requested move (down/left/right/rotate-cw), walks the 16 cells of the
// target 4x4 shape mask in ascending bit order. It checks each occupied cell
// against the board bounds and, through a one-cell synchronous read port,
// against the board contents. It stops at the first failing cell.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   start               request a check (sampled only when idle)
//   dir, piece, rot     requested move, piece code (7 = invalid), current rotation
//   XPOS, YPOS          origin of the piece's 4x4 box
//   rd_row, rd_col      board read address (holds when no read is issued)
//   rd_data             board cell, valid the cycle after the address
//   busy, done          check in progress / one-cycle result strobe
//   canMove             result, held until the next done
//   new_x,new_y,new_rot target position/rotation, valid with done
module move_checker #(
  parameter int unsigned ROWS   = 20,
  parameter int unsigned COLS   = 16,
  parameter int unsigned CELL_W = 3,
  parameter int unsigned ROW_W  = 5,
  parameter int unsigned COL_W  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [1:0]        dir,
  input  logic [2:0]        piece,
  input  logic [1:0]        rot,
  input  logic [COL_W-1:0]  XPOS,
  input  logic [ROW_W-1:0]  YPOS,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              canMove,
  output logic [COL_W-1:0]  new_x,
  output logic [ROW_W-1:0]  new_y,
  output logic [1:0]        new_rot
);

  typedef enum logic [1:0] {StIdle, StScan, StWait, StDone} state_e;

  localparam logic [ROW_W:0] YOne = {{ROW_W{1'b0}}, 1'b1};
  localparam logic [COL_W:0] XOne = {{COL_W{1'b0}}, 1'b1};

  // Cell (r,c) moves to (c,3-r) on a clockwise turn.
  function automatic logic [15:0] rot_cw(input logic [15:0] m);
    logic [15:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[4*c + (3-r)] = m[4*r + c];
      end
    end
    return o;
  endfunction

  function automatic logic [15:0] shape(input logic [2:0] p, input logic [1:0] rt);
    logic [15:0] m;
    case (p)
      3'd0:    m = 16'h00F0;
      3'd1:    m = 16'h0660;
      3'd2:    m = 16'h0360;
      3'd3:    m = 16'h0630;
      3'd4:    m = 16'h0710;
      3'd5:    m = 16'h0740;
      3'd6:    m = 16'h0720;
      default: m = 16'h0000;
    endcase
    // The O piece is rotation-invariant by definition.
    if (p != 3'd1) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(rt)) m = rot_cw(m);
      end
    end
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      mask_q, mask_d;
  logic             invalid_q, invalid_d;
  // Targets are one bit wider than the ports and treated as signed.
  logic [COL_W:0]   xt_q, xt_d;
  logic [ROW_W:0]   yt_q, yt_d;
  logic [1:0]       rt_q, rt_d;
  logic             can_move_q, can_move_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;

  // Two extra bits so Xt+c / Yt+r can neither wrap nor lose their sign.
  logic [ROW_W+1:0] cell_row;
  logic [COL_W+1:0] cell_col;
  logic             cell_oob;

  always_comb begin
    cell_row = {yt_q[ROW_W], yt_q} + {{ROW_W{1'b0}}, idx_q[3:2]};
    cell_col = {xt_q[COL_W], xt_q} + {{COL_W{1'b0}}, idx_q[1:0]};
    cell_oob = cell_row[ROW_W+1] || (cell_row >= (ROW_W+2)'(ROWS)) ||
               cell_col[COL_W+1] || (cell_col >= (COL_W+2)'(COLS));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    invalid_d  = invalid_q;
    xt_d       = xt_q;
    yt_d       = yt_q;
    rt_d       = rt_q;
    can_move_d = can_move_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          xt_d = {1'b0, XPOS};
          yt_d = {1'b0, YPOS};
          rt_d = rot;
          unique case (dir)
            2'b00: yt_d = {1'b0, YPOS} + YOne;
            2'b01: xt_d = {1'b0, XPOS} - XOne;
            2'b10: xt_d = {1'b0, XPOS} + XOne;
            2'b11: rt_d = rot + 2'd1;
          endcase
          mask_d    = shape(piece, rt_d);
          invalid_d = (piece == 3'd7);
          idx_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (mask_q[idx_q]) begin
          if (cell_oob) begin
            can_move_d = 1'b0;
            state_d    = StDone;
          end else begin
            rd_row_d = cell_row[ROW_W-1:0];
            rd_col_d = cell_col[COL_W-1:0];
            state_d  = StWait;
          end
        end else if (idx_q == 4'd15) begin
          can_move_d = !invalid_q;
          state_d    = StDone;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StWait: begin
        if (rd_data != '0) begin
          can_move_d = 1'b0;
          state_d    = StDone;
        end else if (idx_q == 4'd15) begin
          can_move_d = 1'b1;
          state_d    = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StScan;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      mask_q     <= '0;
      invalid_q  <= 1'b0;
      xt_q       <= '0;
      yt_q       <= '0;
      rt_q       <= '0;
      can_move_q <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      invalid_q  <= invalid_d;
      xt_q       <= xt_d;
      yt_q       <= yt_d;
      rt_q       <= rt_d;
      can_move_q <= can_move_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
    end
  end

  // Address goes out in the SCAN cycle so the data lands during WAIT.
  assign rd_row  = rd_row_d;
  assign rd_col  = rd_col_d;
  assign busy    = (state_q == StScan) || (state_q == StWait);
  assign done    = (state_q == StDone);
  assign canMove = can_move_q;
  assign new_x   = xt_q[COL_W-1:0];
  assign new_y   = yt_q[ROW_W-1:0];
  assign new_rot = rt_q;

endmodule

// File: tb/tb_move_checker.sv
// Directed bench for move_checker with a behavioural one-cycle-latency board RAM.
module tb_move_checker;
  localparam int unsigned ROWS = 20, COLS = 16, CELL_W = 3, ROW_W = 5, COL_W = 4;

  logic              Clock = 1'b0;
  logic              Reset, start;
  logic [1:0]        dir, rot;
  logic [2:0]        piece;
  logic [COL_W-1:0]  XPOS;
  logic [ROW_W-1:0]  YPOS;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [CELL_W-1:0] rd_data;
  logic              busy, done, canMove;
  logic [COL_W-1:0]  new_x;
  logic [ROW_W-1:0]  new_y;
  logic [1:0]        new_rot;

  move_checker #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .dir(dir), .piece(piece), .rot(rot),
    .XPOS(XPOS), .YPOS(YPOS), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .done(done), .canMove(canMove), .new_x(new_x), .new_y(new_y),
    .new_rot(new_rot)
  );

  always #5 Clock = ~Clock;

  logic [CELL_W-1:0] board [32][16];
  always @(posedge Clock) rd_data <= board[rd_row][rd_col];

  int n_chk = 0, n_fail = 0;
  int n_log = 0, n_done = 0;
  logic [ROW_W-1:0] log_row [64];
  logic [COL_W-1:0] log_col [64];
  logic [ROW_W+COL_W-1:0] last_addr = '0;

  // A read is logged whenever the address changes while busy.
  always @(negedge Clock) begin
    if (busy === 1'b1 && {rd_row, rd_col} != last_addr) begin
      if (n_log < 64) begin
        log_row[n_log] <= rd_row;
        log_col[n_log] <= rd_col;
      end
      n_log <= n_log + 1;
    end
    last_addr <= {rd_row, rd_col};
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int i, input int er, input int ec);
    check(tag, 32'(int'(log_row[i]) * 16 + int'(log_col[i])), 32'(er * 16 + ec));
  endtask

  // Issues one start and counts cycles until done (cycle 1 follows the sampling edge).
  task automatic run_check(input logic [2:0] p, input logic [1:0] r, input logic [COL_W-1:0] x,
                           input logic [ROW_W-1:0] y, input logic [1:0] d,
                           output int cyc, output int base);
    @(negedge Clock);
    piece = p; rot = r; XPOS = x; YPOS = y; dir = d; start = 1'b1;
    base = n_log;
    @(negedge Clock);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge Clock);
      cyc++;
    end
    @(posedge Clock);
    #1;
  endtask

  int cyc, base, base_done;

  initial begin
    for (int r = 0; r < 32; r++) for (int c = 0; c < 16; c++) board[r][c] = '0;
    Reset = 1'b1; start = 1'b0; dir = '0; piece = '0; rot = '0; XPOS = '0; YPOS = '0;
    repeat (3) @(negedge Clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset canMove", 32'(canMove), 32'd0);
    check("reset new_x", 32'(new_x), 32'd0);
    check("reset new_y", 32'(new_y), 32'd0);
    check("reset new_rot", 32'(new_rot), 32'd0);
    check("reset rd_row", 32'(rd_row), 32'd0);
    check("reset rd_col", 32'(rd_col), 32'd0);
    Reset = 1'b0;

    // 1: O down on empty board
    run_check(3'd1, 2'd0, 4'd5, 5'd0, 2'b00, cyc, base);
    check("t1 latency", 32'(cyc), 32'd21);
    check("t1 nreads", 32'(n_log - base), 32'd4);
    chk_rd("t1 rd0", base, 2, 6);
    chk_rd("t1 rd1", base + 1, 2, 7);
    chk_rd("t1 rd2", base + 2, 3, 6);
    chk_rd("t1 rd3", base + 3, 3, 7);
    check("t1 canMove", 32'(canMove), 32'd1);
    check("t1 new_x", 32'(new_x), 32'd5);
    check("t1 new_y", 32'(new_y), 32'd1);

    // 2: occupied cell (2,7) stops the scan at the second read
    board[2][7] = 3'b010;
    run_check(3'd1, 2'd0, 4'd5, 5'd0, 2'b00, cyc, base);
    check("t2 latency", 32'(cyc), 32'd10);
    check("t2 nreads", 32'(n_log - base), 32'd2);
    chk_rd("t2 rd1", base + 1, 2, 7);
    check("t2 canMove", 32'(canMove), 32'd0);
    check("t2 rd_row hold", 32'(rd_row), 32'd2);
    check("t2 rd_col hold", 32'(rd_col), 32'd7);
    board[2][7] = '0;

    // 3: I left from column 0
    run_check(3'd0, 2'd0, 4'd0, 5'd4, 2'b01, cyc, base);
    check("t3 latency", 32'(cyc), 32'd6);
    check("t3 nreads", 32'(n_log - base), 32'd0);
    check("t3 canMove", 32'(canMove), 32'd0);
    check("t3 new_x", 32'(new_x), 32'hF);
    check("t3 new_y", 32'(new_y), 32'd4);

    // 4: O down into the floor
    run_check(3'd1, 2'd0, 4'd5, 5'd17, 2'b00, cyc, base);
    check("t4 latency", 32'(cyc), 32'd13);
    check("t4 nreads", 32'(n_log - base), 32'd2);
    chk_rd("t4 rd0", base, 19, 6);
    chk_rd("t4 rd1", base + 1, 19, 7);
    check("t4 canMove", 32'(canMove), 32'd0);
    check("t4 new_y", 32'(new_y), 32'd18);

    // 5a: I right off the right wall
    run_check(3'd0, 2'd0, 4'd13, 5'd0, 2'b10, cyc, base);
    check("t5a latency", 32'(cyc), 32'd10);
    check("t5a nreads", 32'(n_log - base), 32'd2);
    chk_rd("t5a rd0", base, 1, 14);
    chk_rd("t5a rd1", base + 1, 1, 15);
    check("t5a canMove", 32'(canMove), 32'd0);
    check("t5a new_x", 32'(new_x), 32'd14);

    // 5b: T rotate from 3 wraps to 0 (mask 0x0720)
    run_check(3'd6, 2'd3, 4'd6, 5'd6, 2'b11, cyc, base);
    check("t5b latency", 32'(cyc), 32'd21);
    chk_rd("t5b rd0", base, 7, 7);
    chk_rd("t5b rd1", base + 1, 8, 6);
    chk_rd("t5b rd2", base + 2, 8, 7);
    chk_rd("t5b rd3", base + 3, 8, 8);
    check("t5b canMove", 32'(canMove), 32'd1);
    check("t5b new_rot", 32'(new_rot), 32'd0);

    // Invalid piece: no reads, 16 scan cycles, forced fail
    run_check(3'd7, 2'd0, 4'd5, 5'd0, 2'b00, cyc, base);
    check("inv latency", 32'(cyc), 32'd17);
    check("inv nreads", 32'(n_log - base), 32'd0);
    check("inv canMove", 32'(canMove), 32'd0);

    // I rotate 0->1 gives a vertical bar in column 2 (mask 0x4444)
    run_check(3'd0, 2'd0, 4'd0, 5'd0, 2'b11, cyc, base);
    check("irot latency", 32'(cyc), 32'd21);
    chk_rd("irot rd0", base, 0, 2);
    chk_rd("irot rd3", base + 3, 3, 2);
    check("irot canMove", 32'(canMove), 32'd1);
    check("irot new_rot", 32'(new_rot), 32'd1);

    // 6a: reset during the first WAIT (cycle 7) aborts with no done
    @(negedge Clock);
    piece = 3'd1; rot = 2'd0; XPOS = 4'd5; YPOS = 5'd0; dir = 2'b00; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (6) @(negedge Clock);
    check("t6 busy in wait", 32'(busy), 32'd1);
    base_done = n_done;
    Reset = 1'b1;
    @(negedge Clock);
    check("t6 busy after reset", 32'(busy), 32'd0);
    check("t6 canMove after reset", 32'(canMove), 32'd0);
    Reset = 1'b0;
    repeat (30) @(negedge Clock);
    check("t6 no done", 32'(n_done - base_done), 32'd0);
    check("t6 canMove held", 32'(canMove), 32'd0);

    // 6b: start while busy and during DONE is ignored
    base_done = n_done;
    piece = 3'd1; rot = 2'd0; XPOS = 4'd5; YPOS = 5'd0; dir = 2'b00; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    cyc = 1;
    repeat (2) @(negedge Clock);
    cyc += 2;
    piece = 3'd0; dir = 2'b01; start = 1'b1;
    @(negedge Clock);
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge Clock);
      cyc++;
    end
    check("t6b latency", 32'(cyc), 32'd21);
    check("t6b canMove", 32'(canMove), 32'd1);
    check("t6b new_x", 32'(new_x), 32'd5);
    check("t6b new_y", 32'(new_y), 32'd1);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    check("t6b start in done", 32'(busy), 32'd0);
    repeat (30) @(negedge Clock);
    check("t6b one done", 32'(n_done - base_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_checker.md
Name: move_checker

Overview:
- Parametrised, sequential successor to the down-only collision check.
- Checks whether the active tetromino can move down, move left, move right or rotate clockwise, for all 7 pieces in all 4 rotations.
- Reads the board through a single synchronous read port, one cell per access, instead of taking the whole board as a flat input.
- Sits between the game-control FSM, which issues start and consumes done/canMove, and the board RAM.

Parameters:
- ROWS, 20, board height in cells.
- COLS, 16, board width in cells.
- CELL_W, 3, bits per board cell; 0 means empty.
- ROW_W, 5, width of row indices; must satisfy 2^ROW_W >= ROWS.
- COL_W, 4, width of column indices; must satisfy 2^COL_W >= COLS.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request a check; sampled only in IDLE.
- dir  in  2  requested move: 00 down, 01 left, 10 right, 11 rotate clockwise.
- piece  in  3  piece code: 0 I, 1 O, 2 S, 3 Z, 4 J, 5 L, 6 T; 7 is invalid.
- rot  in  2  current rotation.
- XPOS  in  COL_W  column of the piece's 4x4 box origin.
- YPOS  in  ROW_W  row of the piece's 4x4 box origin.
- rd_row  out  ROW_W  board read row address.
- rd_col  out  COL_W  board read column address.
- rd_data  in  CELL_W  board cell contents, valid one cycle after the address is driven.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when the result is ready.
- canMove  out  1  result; held until the next done.
- new_x  out  COL_W  target column; valid with done.
- new_y  out  ROW_W  target row; valid with done.
- new_rot  out  2  target rotation; valid with done.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (Clock, Reset).
- Reset values: all outputs 0. Reset during a check aborts it: FSM returns to IDLE, no done pulse.

Shape ROM:
- 16-bit mask per piece/rotation; bit 4r+c set means cell (r,c) of the 4x4 box is occupied.
- Rotation-0 masks: I 0x00F0, O 0x0660, S 0x0360, Z 0x0630, J 0x0710, L 0x0740, T 0x0720.
- Rotation k+1 is rotation k with cell (r,c) mapped to (c,3-r).
- O uses 0x0660 for every rotation.

Target computation (latched on start acceptance):
- down: Yt=YPOS+1, Xt=XPOS, Rt=rot.
- left: Xt=XPOS-1.
- right: Xt=XPOS+1.
- rotate: Rt=rot+1 mod 4, position unchanged.
- Xt and Yt are held one bit wider than their ports and signed, so XPOS=0 with left gives Xt=-1.
- new_x/new_y/new_rot output the low bits of Xt/Yt/Rt.

FSM states: IDLE, SCAN, WAIT, DONE.
- IDLE: busy=0. On start: latch all inputs and targets, set idx=0, go to SCAN, busy=1. start is ignored while busy.
- SCAN, one mask bit per cycle:
  - If bit idx of the Rt mask is clear: idx++.
  - If set, compute cell row=Yt+r and col=Xt+c.
  - If row>=ROWS, col<0 or col>=COLS: fail, canMove:=0, go to DONE with no read.
  - Otherwise drive rd_row/rd_col and go to WAIT.
  - After idx=15 with no failure: canMove:=1, go to DONE.
- WAIT: if rd_data!=0, fail (canMove:=0, go to DONE); otherwise idx++ and return to SCAN (or go to DONE with canMove:=1 if idx was 15).
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE. start is not accepted in the DONE cycle.

Latency:
- Successful check: 16 SCAN cycles plus 4 WAIT cycles; done is high in the 21st cycle after the start-sampling edge.
- A failure terminates early, at the first failing cell.
- Cells are visited in ascending bit order.

Invalid piece (7): treated as an empty mask with a forced result of canMove=0; done follows after 16 SCAN cycles with no reads.

rd_row/rd_col hold their last value when no read is being issued.

Test Plan:
1. Empty board (rd_data=0); O, rot0, X=5, Y=0, dir=down -> reads (2,6),(2,7),(3,6),(3,7) in that order; done on cycle 21; canMove=1; new_y=1, new_x=5.
2. Same as 1 with board cell (2,7)=3'b010 -> exactly 2 reads; done early; canMove=0.
3. I, rot0, X=0, Y=4, dir=left -> bit 4 gives col -1, out of bounds; zero reads; canMove=0; new_x=4'hF.
4. O, rot0, X=5, Y=17, dir=down -> cell row 20 >= ROWS: fail after reads (19,6),(19,7), before any row-20 access; canMove=0.
5. I, rot0, X=13, dir=right -> col 17 out of bounds, canMove=0. T, rot3, X=6, Y=6, dir=rotate on empty board -> new_rot=0, canMove=1.
6. Assert Reset while in WAIT -> next cycle busy=0, done never pulses, canMove=0. start pulsed while busy -> ignored; exactly one done per accepted start.
